// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the decryption datapath.
//   - AES_BLOCK_BYTES, AES_POLY, INV_AFFINE_C, FWD_AFFINE_C constants
//   - aes_byte_t (8-bit) and aes_state_t (16 packed bytes, byte i = bits 8i+7:8i)
//   - fsm_state_e: IDLE / BUSY / DONE for the sequential byte engines
//   - GF(2^8) helpers: gf_mul, gf_inv, inv_affine, fwd_affine
package aes_pkg;

  localparam int        AES_BLOCK_BYTES = 16;
  localparam logic [7:0] AES_POLY       = 8'h1B;  // x^8 + x^4 + x^3 + x + 1, low byte
  localparam logic [7:0] INV_AFFINE_C   = 8'h05;
  localparam logic [7:0] FWD_AFFINE_C   = 8'h63;

  typedef logic [7:0] aes_byte_t;
  typedef aes_byte_t [AES_BLOCK_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Shift-and-add multiply in GF(2^8), reducing by AES_POLY on each carry out.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t acc;
    aes_byte_t aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? AES_POLY : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128.
  // Zero maps to zero naturally, so no special case is needed.
  function automatic aes_byte_t gf_inv(input aes_byte_t a);
    aes_byte_t sq;
    aes_byte_t prod;
    sq   = gf_mul(a, a);
    prod = sq;
    for (int k = 2; k < 8; k++) begin
      sq   = gf_mul(sq, sq);
      prod = gf_mul(prod, sq);
    end
    return prod;
  endfunction

  // y[i] = x[i+2] ^ x[i+5] ^ x[i+7] ^ c[i], indices mod 8.
  function automatic aes_byte_t inv_affine(input aes_byte_t x);
    aes_byte_t y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ INV_AFFINE_C[i];
    end
    return y;
  endfunction

  // Forward counterpart, kept beside the inverse for the encrypt datapath.
  function automatic aes_byte_t fwd_affine(input aes_byte_t x);
    aes_byte_t y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8]
             ^ FWD_AFFINE_C[i];
    end
    return y;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// inv_sbox: combinational AES inverse S-box (FIPS-197 InvSubBytes table).
//   in_byte   in  8  byte to substitute
//   out_byte  out 8  InvS(in_byte) = field inverse of the inverse affine image
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = gf_inv(inv_affine(in_byte));

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes engine.
// Accepts one 128-bit state, substitutes LANES bytes per cycle through LANES
// shared inverse S-boxes, and holds the result until the consumer takes it.
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    in_data is valid
//   in_ready   out  1    engine idle, can accept a state
//   in_data    in   128  state; byte i = in_data[8i+7:8i]
//   out_valid  out  1    out_data holds a finished state
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  substituted state, same byte mapping
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int JOBS  = AES_BLOCK_BYTES / LANES;
  localparam int IDX_W = (JOBS > 1) ? $clog2(JOBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(JOBS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  aes_state_t         work_q, work_d;

  logic [3:0]         lane_sel [LANES];
  aes_byte_t          sbox_in  [LANES];
  aes_byte_t          sbox_out [LANES];

  // Lane l works on byte idx*LANES + l of the work register.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_sel[l] = 4'(int'(idx_q) * LANES + l);
      sbox_in[l]  = work_q[lane_sel[l]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .in_byte  (sbox_in[g]),
      .out_byte (sbox_out[g])
    );
  end

  // NOTE: the work register is a flop bank, not a RAM, so it takes a reset
  // value like any other state; this also makes out_data deterministic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
    end
  end

  // Handshake outputs decode only the registered state, so neither in_valid
  // nor out_ready reaches an output combinationally.
  always_comb begin
    // NOTE: every signal written here gets a default first; without it, any
    // path that skips an assignment would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = aes_state_t'(in_data);
          idx_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[lane_sel[l]] = sbox_out[l];
        end
        // idx holds on the last step so it never wraps inside a job.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_data = work_q;

endmodule
